player_input_ctrl: RTL and testbench
====================================

Name: player_input_ctrl

Overview:
- Sequences the player's ship controls between the debounced button front-end and the ship/missile datapath.
- Converts fire pulses into single missile launches. Only one player missile is in flight at a time, and a post-impact cooldown applies.
- Converts held left/right buttons into step pulses with press-immediate, delay, then auto-repeat timing, paced by the frame tick.

Parameters:
- DELAY_FRAMES, 8: frame ticks between the first step and the first repeat step.
- REPEAT_FRAMES, 2: frame ticks between repeat steps; minimum 1.
- COOLDOWN_FRAMES, 4: frame ticks after missile end before the next launch is allowed; 0 means no cooldown.
- CNT_W, 4: tick counter width; must hold the largest of the three *_FRAMES values.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-low reset.
- frame_tick, in, 1: one-cycle pulse, once per video frame.
- enable, in, 1: game running; low during pause and game-over.
- fire_pulse, in, 1: one-cycle press pulse from the fire button front-end.
- left_held, in, 1: left button level, synchronised.
- right_held, in, 1: right button level, synchronised.
- missile_active, in, 1: missile datapath reports a missile in flight.
- launch, out, 1: one-cycle launch command to the missile datapath.
- step_left, out, 1: one-cycle ship move-left command.
- step_right, out, 1: one-cycle ship move-right command.
- fire_ready, out, 1: high when a fire_pulse would be accepted this cycle.

Behaviour:
- All outputs are registered. During reset and immediately after it, every output is 0, both FSMs are in their idle state and all counters are 0.
- Reset asserted mid-operation aborts any launch, cooldown or repeat sequence.
- Fire FSM states and transitions:
  - F_IDLE -> F_LAUNCH on fire_pulse & enable.
  - F_LAUNCH lasts exactly 1 cycle with launch=1, then goes to F_WAIT.
  - F_WAIT -> F_FLY when missile_active=1.
  - F_FLY -> F_COOL when missile_active=0.
  - F_COOL counts frame_ticks; after COOLDOWN_FRAMES ticks -> F_IDLE. If COOLDOWN_FRAMES=0, F_FLY goes straight to F_IDLE.
- Fire latency: launch is high in the cycle after the fire_pulse cycle.
- fire_pulse outside F_IDLE, or while enable=0, is dropped (default build).
- fire_ready = (state==F_IDLE) & enable.
- enable falling does not abort F_WAIT, F_FLY or F_COOL; the missile in flight completes normally.
- Move FSM states: M_IDLE, M_DELAY, M_REPEAT. dir = left only, right only, or none. Both buttons held counts as none.
- M_IDLE, dir becomes left or right with enable=1: the step pulse for dir is issued next cycle; go to M_DELAY; counter cleared.
- M_DELAY: count frame_ticks; on the DELAY_FRAMES-th tick, issue a step and go to M_REPEAT with the counter cleared.
- M_REPEAT: issue a step on every REPEAT_FRAMES-th tick.
- In any state, if dir becomes none or enable=0: go to M_IDLE with no step.
- In any state, if dir changes left<->right directly: restart as a fresh press in the new direction (immediate step, M_DELAY).
- step_left and step_right are never high in the same cycle.
- A frame_tick coinciding with a press or direction change is not counted toward the new delay.
- Counters saturate-free: each clears on every state entry, and a compare on ==N-1 at a tick completes the count.

Optional Feature:
- Macro FIRE_QUEUE_EN.
- Defined: one pending-fire flag. A fire_pulse arriving in F_WAIT, F_FLY or F_COOL with enable=1 sets the flag. On entering F_IDLE with the flag set, go straight to F_LAUNCH and clear the flag. The flag is cleared by enable=0 and by reset. fire_ready is unchanged.
- Undefined: no flag; such pulses are dropped.

Decomposition:
- Shared game package holds:
  - fire state encodings F_IDLE..F_COOL (3 bits);
  - move state encodings M_IDLE..M_REPEAT (2 bits);
  - default frame constants shared with the ship/missile datapath.
- One sub-module is natural: frame_counter (clear, frame_tick, terminal count N, done pulse).
  - Instantiated twice: fire cooldown and move delay/repeat.

Test Plan:
- Fire: fire_pulse at cycle 10, missile_active high for cycles 12-40. Required: launch=1 only at cycle 11; fire_ready low from 11. fire_ready returns high in the cycle after the 4th frame_tick following cycle 40.
- Drop vs queue: fire_pulse during F_FLY. Default build: no second launch. FIRE_QUEUE_EN build: a second launch occurs exactly one cycle after F_IDLE is re-entered.
- Auto-repeat: left_held high for 14 frames, frame_tick every 16 cycles. Required: step_left the cycle after press, then at the 8th tick, then every 2nd tick. Total 1+1+3 = 5 pulses; none after release.
- Both held: right_held high, then left_held also high at tick 3. Required: steps stop immediately. After left releases, right restarts with an immediate step.
- Enable: enable drops during M_REPEAT and during F_FLY. Required: step pulses stop immediately. The missile still finishes and cooldown runs; no launch occurs while enable=0.
- Reset: reset pulled low during F_COOL and M_DELAY. Required: all outputs 0 asynchronously. After release, fire_ready=1 once enable=1.

Source files
------------

// File: rtl/player_input_ctrl_pkg.sv
// Shared game definitions: fire/move FSM encodings, button direction decode and
// default frame timing constants used by the ship/missile datapath as well.
package player_input_ctrl_pkg;

  typedef enum logic [2:0] {
    F_IDLE   = 3'd0,
    F_LAUNCH = 3'd1,
    F_WAIT   = 3'd2,
    F_FLY    = 3'd3,
    F_COOL   = 3'd4
  } fire_state_t;

  typedef enum logic [1:0] {
    M_IDLE   = 2'd0,
    M_DELAY  = 2'd1,
    M_REPEAT = 2'd2
  } move_state_t;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_RIGHT = 2'd2
  } dir_t;

  localparam int DEF_DELAY_FRAMES    = 8;
  localparam int DEF_REPEAT_FRAMES   = 2;
  localparam int DEF_COOLDOWN_FRAMES = 4;
  localparam int DEF_CNT_W           = 4;

  // Both buttons held cancel each other out.
  function automatic dir_t decode_dir(input logic left, input logic right);
    dir_t d;
    case ({left, right})
      2'b10:   d = DIR_LEFT;
      2'b01:   d = DIR_RIGHT;
      default: d = DIR_NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/player_input_ctrl_frame_counter.sv
// Frame tick counter: done pulses combinationally on the tick that completes a
// count of `terminal` ticks; clear has priority and discards a coincident tick.
module player_input_ctrl_frame_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             frame_tick,
  input  logic [CNT_W-1:0] terminal,
  output logic             done
);

  localparam logic [CNT_W-1:0] ONE = 1;

  logic [CNT_W-1:0] cnt;

  assign done = frame_tick && (cnt == terminal - ONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear || done) begin
      cnt <= '0;
    end else if (frame_tick) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/player_input_ctrl.sv
// Player control sequencer: fire pulses -> single missile launches with cooldown,
// held left/right -> step pulses with delay and auto-repeat. FIRE_QUEUE_EN adds a pending-fire flag.
module player_input_ctrl
  import player_input_ctrl_pkg::*;
#(
  parameter int DELAY_FRAMES    = DEF_DELAY_FRAMES,
  parameter int REPEAT_FRAMES   = DEF_REPEAT_FRAMES,
  parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic       fire_pulse,
  input  logic       left_held,
  input  logic       right_held,
  input  logic       missile_active,
  output logic       launch,
  output logic       step_left,
  output logic       step_right,
  output logic       fire_ready,
  output logic [2:0] fire_state_dbg,
  output logic [1:0] move_state_dbg
);

  localparam logic [CNT_W-1:0] DELAY_N  = CNT_W'(DELAY_FRAMES);
  localparam logic [CNT_W-1:0] REPEAT_N = CNT_W'(REPEAT_FRAMES);
  localparam logic [CNT_W-1:0] COOL_N   = CNT_W'(COOLDOWN_FRAMES);

  fire_state_t fire_state, fire_next;
  move_state_t move_state, move_next;
  dir_t        dir_q, dir_next, dir_in, step_dir;
  logic        pend;
  logic        cool_done, move_done, move_clear;

  assign fire_state_dbg = fire_state;
  assign move_state_dbg = move_state;
  assign dir_in         = decode_dir(left_held, right_held);

  // fire_pulse is a one-cycle request; it is taken only in a cycle where
  // fire_ready would have been high, otherwise it is dropped (or queued).
  always_comb begin
    fire_next = fire_state;
    case (fire_state)
      F_IDLE:   if (enable && (fire_pulse || pend)) fire_next = F_LAUNCH;
      F_LAUNCH: fire_next = F_WAIT;
      F_WAIT:   if (missile_active) fire_next = F_FLY;
      F_FLY:    if (!missile_active) fire_next = (COOLDOWN_FRAMES == 0) ? F_IDLE : F_COOL;
      F_COOL:   if (cool_done) fire_next = F_IDLE;
      default:  fire_next = F_IDLE;
    endcase
  end

`ifdef FIRE_QUEUE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend <= 1'b0;
    end else if (!enable || fire_state == F_IDLE) begin
      pend <= 1'b0;
    end else if (fire_pulse && (fire_state == F_WAIT || fire_state == F_FLY ||
                                fire_state == F_COOL)) begin
      pend <= 1'b1;
    end
  end
`else
  assign pend = 1'b0;
`endif

  always_comb begin
    move_next  = move_state;
    dir_next   = dir_q;
    step_dir   = DIR_NONE;
    move_clear = 1'b0;
    case (move_state)
      M_IDLE: begin
        move_clear = 1'b1;
        if (enable && dir_in != DIR_NONE) begin
          move_next = M_DELAY;
          dir_next  = dir_in;
          step_dir  = dir_in;
        end
      end
      M_DELAY, M_REPEAT: begin
        if (!enable || dir_in == DIR_NONE) begin
          move_next  = M_IDLE;
          dir_next   = DIR_NONE;
          move_clear = 1'b1;
        end else if (dir_in != dir_q) begin
          // direct reversal behaves like a fresh press
          move_next  = M_DELAY;
          dir_next   = dir_in;
          step_dir   = dir_in;
          move_clear = 1'b1;
        end else if (move_done) begin
          move_next  = M_REPEAT;
          step_dir   = dir_q;
          move_clear = (move_state == M_DELAY);
        end
      end
      default: begin
        move_next  = M_IDLE;
        dir_next   = DIR_NONE;
        move_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fire_state <= F_IDLE;
      move_state <= M_IDLE;
      dir_q      <= DIR_NONE;
      launch     <= 1'b0;
      step_left  <= 1'b0;
      step_right <= 1'b0;
      fire_ready <= 1'b0;
    end else begin
      fire_state <= fire_next;
      move_state <= move_next;
      dir_q      <= dir_next;
      launch     <= (fire_next == F_LAUNCH);
      fire_ready <= (fire_next == F_IDLE) && enable;
      step_left  <= (step_dir == DIR_LEFT);
      step_right <= (step_dir == DIR_RIGHT);
    end
  end

  player_input_ctrl_frame_counter #(.CNT_W(CNT_W)) u_cool_cnt (
    .clk        (clk),
    .reset      (reset),
    .clear      (fire_state != F_COOL),
    .frame_tick (frame_tick),
    .terminal   (COOL_N),
    .done       (cool_done)
  );

  player_input_ctrl_frame_counter #(.CNT_W(CNT_W)) u_move_cnt (
    .clk        (clk),
    .reset      (reset),
    .clear      (move_clear),
    .frame_tick (frame_tick),
    .terminal   ((move_state == M_REPEAT) ? REPEAT_N : DELAY_N),
    .done       (move_done)
  );

endmodule

// File: tb/tb_player_input_ctrl.sv
// Bench for player_input_ctrl: directed scenarios push expected pulse cycles,
// a negedge monitor pops and compares whenever launch/step pulses appear.
module tb_player_input_ctrl;
  import player_input_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset, frame_tick, enable, fire_pulse, left_held, right_held, missile_active;
  logic       launch, step_left, step_right, fire_ready;
  logic [2:0] fire_state_dbg;
  logic [1:0] move_state_dbg;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  logic [31:0] exp_launch_q[$];
  logic [31:0] exp_left_q[$];
  logic [31:0] exp_right_q[$];

  player_input_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .frame_tick     (frame_tick),
    .enable         (enable),
    .fire_pulse     (fire_pulse),
    .left_held      (left_held),
    .right_held     (right_held),
    .missile_active (missile_active),
    .launch         (launch),
    .step_left      (step_left),
    .step_right     (step_right),
    .fire_ready     (fire_ready),
    .fire_state_dbg (fire_state_dbg),
    .move_state_dbg (move_state_dbg)
  );

  // clock / reset-independent cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "bench time limit");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: cycle %0d got %0h want %0h", name, cyc, got, want);
    end
  endtask

  task automatic mon_pulse(input int which);
    logic [31:0] e;
    string       name;
    int          n;
    case (which)
      0:       begin name = "launch";     n = exp_launch_q.size(); end
      1:       begin name = "step_left";  n = exp_left_q.size();   end
      default: begin name = "step_right"; n = exp_right_q.size();  end
    endcase
    compared++;
    if (n == 0) begin
      mismatched++;
      $display("FAIL %s: unexpected pulse at cycle %0d, none required", name, cyc);
    end else begin
      case (which)
        0:       e = exp_launch_q.pop_front();
        1:       e = exp_left_q.pop_front();
        default: e = exp_right_q.pop_front();
      endcase
      if (e != 32'(cyc)) begin
        mismatched++;
        $display("FAIL %s: pulse at cycle %0d, required at cycle %0d", name, cyc, e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (launch)     mon_pulse(0);
    if (step_left)  mon_pulse(1);
    if (step_right) mon_pulse(2);
    if (step_left || step_right) begin
      compared++;
      if (step_left && step_right) begin
        mismatched++;
        $display("FAIL step_exclusive: both steps high at cycle %0d, required one", cyc);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    frame_tick = 1'b0; fire_pulse = 1'b0; left_held = 1'b0;
    right_held = 1'b0; missile_active = 1'b0;
  endtask

  task automatic drain_check(input string name);
    compared++;
    if (exp_launch_q.size() + exp_left_q.size() + exp_right_q.size() != 0) begin
      mismatched++;
      $display("FAIL %s_missing: pending launch/left/right %0d/%0d/%0d, required 0/0/0",
               name, exp_launch_q.size(), exp_left_q.size(), exp_right_q.size());
    end
    exp_launch_q.delete(); exp_left_q.delete(); exp_right_q.delete();
  endtask

  task automatic sc_fire();
    int base;
    base = cyc + 1;
    exp_launch_q.push_back(base + 11);
    for (int r = 0; r <= 110; r++) begin
      next_cycle();
      if (r == 10)  check("fire_ready_idle", fire_ready, 1);
      if (r == 11)  check("fire_ready_launch", fire_ready, 0);
      if (r == 104) check("fire_ready_cool", fire_ready, 0);
      if (r == 105) check("fire_ready_back", fire_ready, 1);
      fire_pulse     = (r == 10);
      missile_active = (r >= 12 && r <= 40);
      frame_tick     = (r % 16 == 8);
    end
    idle_inputs();
    drain_check("fire");
  endtask

  task automatic sc_queue();
    int base;
    base = cyc + 1;
    exp_launch_q.push_back(base + 3);
`ifdef FIRE_QUEUE_EN
    exp_launch_q.push_back(base + 74);
`endif
    for (int r = 0; r <= 140; r++) begin
      next_cycle();
      if (r == 10) check("fire_ready_fly", fire_ready, 0);
      if (r == 73) check("fire_ready_reidle", fire_ready, 1);
      fire_pulse     = (r == 2) || (r == 10);
      missile_active = (r >= 4 && r <= 20) || (r >= 76 && r <= 80);
      frame_tick     = (r % 16 == 8);
    end
    idle_inputs();
    drain_check("queue");
  endtask

  task automatic sc_repeat();
    int base;
    base = cyc + 1;
    exp_left_q.push_back(base + 3);
    exp_left_q.push_back(base + 121);
    exp_left_q.push_back(base + 153);
    exp_left_q.push_back(base + 185);
    exp_left_q.push_back(base + 217);
    for (int r = 0; r <= 260; r++) begin
      next_cycle();
      if (r == 100) check("move_delay_state", move_state_dbg, M_DELAY);
      if (r == 130) check("move_repeat_state", move_state_dbg, M_REPEAT);
      left_held  = (r >= 2 && r < 220);
      frame_tick = (r % 16 == 8);
    end
    idle_inputs();
    drain_check("repeat");
  endtask

  task automatic sc_both();
    int base;
    base = cyc + 1;
    exp_right_q.push_back(base + 3);
    exp_right_q.push_back(base + 61);
    exp_right_q.push_back(base + 89);
    exp_right_q.push_back(base + 217);
    exp_left_q.push_back(base + 81);
    for (int r = 0; r <= 230; r++) begin
      next_cycle();
      if (r == 45) check("both_held_idle", move_state_dbg, M_IDLE);
      right_held = (r >= 2 && r < 70) || (r >= 88 && r < 220);
      left_held  = (r >= 40 && r < 60) || (r >= 80 && r < 88);
      frame_tick = (r % 16 == 8);
    end
    idle_inputs();
    drain_check("both");
  endtask

  task automatic sc_enable();
    int base;
    base = cyc + 1;
    exp_launch_q.push_back(base + 3);
    exp_left_q.push_back(base + 3);
    exp_left_q.push_back(base + 121);
    for (int r = 0; r <= 230; r++) begin
      next_cycle();
      if (r == 145) check("enable_move_idle", move_state_dbg, M_IDLE);
      if (r == 150) check("enable_fly_kept", fire_state_dbg, F_FLY);
      if (r == 180) check("enable_cool_runs", fire_state_dbg, F_COOL);
      if (r == 218) check("enable_cool_done", fire_state_dbg, F_IDLE);
      if (r == 218) check("fire_ready_disabled", fire_ready, 0);
      if (r == 226) check("fire_ready_reenabled", fire_ready, 1);
      enable         = !(r >= 140 && r < 225);
      fire_pulse     = (r == 2) || (r == 145) || (r == 220);
      missile_active = (r >= 5 && r <= 160);
      left_held      = (r >= 2 && r < 142);
      frame_tick     = (r % 16 == 8);
    end
    idle_inputs();
    enable = 1'b1;
    drain_check("enable");
  endtask

  task automatic sc_reset();
    int base;
    base = cyc + 1;
    exp_launch_q.push_back(base + 3);
    exp_right_q.push_back(base + 3);
    for (int r = 0; r <= 40; r++) begin
      next_cycle();
      if (r == 30) begin
        check("pre_reset_cool", fire_state_dbg, F_COOL);
        check("pre_reset_delay", move_state_dbg, M_DELAY);
        reset = 1'b0;
        #1;
        check("async_fire_state", fire_state_dbg, F_IDLE);
        check("async_move_state", move_state_dbg, M_IDLE);
        check("async_outputs", {launch, step_left, step_right, fire_ready}, 4'b0000);
      end
      if (r == 34) check("in_reset_outputs", {launch, step_left, step_right, fire_ready}, 4'b0000);
      if (r == 34) reset = 1'b1;
      if (r == 35) check("post_reset_ready", fire_ready, 1);
      if (r == 36) check("post_reset_move", move_state_dbg, M_IDLE);
      fire_pulse     = (r == 2);
      missile_active = (r >= 5 && r <= 10);
      right_held     = (r >= 2 && r < 32);
      frame_tick     = (r % 16 == 8);
    end
    idle_inputs();
    drain_check("reset");
  endtask

  initial begin
    reset = 1'b0;
    enable = 1'b0;
    idle_inputs();
    repeat (3) next_cycle();
    check("reset_outputs", {launch, step_left, step_right, fire_ready}, 4'b0000);
    check("reset_fire_state", fire_state_dbg, F_IDLE);
    check("reset_move_state", move_state_dbg, M_IDLE);
    reset = 1'b1;
    next_cycle();
    check("release_outputs", {launch, step_left, step_right, fire_ready}, 4'b0000);
    enable = 1'b1;
    next_cycle();
    check("release_fire_ready", fire_ready, 1);

    sc_fire();
    sc_queue();
    sc_repeat();
    sc_both();
    sc_enable();
    sc_reset();
    repeat (4) next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
